// File: rtl/gray_counter.sv
// Free-running reflected-binary Gray counter. A binary count register drives
// a registered Gray output, so the output only ever changes at a clock edge.
module gray_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] Gray_output
);

   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_next;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign bin_next = bin + WIDTH'(1);

   // The Gray register is loaded from bin_next so it tracks bin on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bin         <= '0;
         Gray_output <= '0;
      end else begin
         bin         <= bin_next;
         Gray_output <= to_gray(bin_next);
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=3 and WIDTH=4, with the expected
// codes taken from a reflect-and-prefix construction of the Gray sequence.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst3 = 1'b0;
   logic       rst4 = 1'b0;
   logic [2:0] g3;
   logic [3:0] g4;

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst3), .Gray_output(g3));
   gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .Gray_output(g4));

   typedef struct {
      logic [15:0] gray;
      bit          onebit;
   } exp_t;

   exp_t        q3[$];
   exp_t        q4[$];
   logic [15:0] tab [0:15];
   int          checks = 0;
   int          errors = 0;
   int          k3 = 0;
   int          k4 = 0;
   bit          v3 = 1'b0;
   bit          v4 = 1'b0;

   function automatic void check(input string name, input logic [15:0] act,
                                 input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void adv3(input bit r);
      exp_t e;
      e.onebit = 1'b0;
      if (!r) begin
         k3 = 0;
         v3 = 1'b1;
      end else if (v3) begin
         k3 = (k3 + 1) % 8;
         e.onebit = 1'b1;
      end
      if (v3) begin
         e.gray = tab[k3];
         q3.push_back(e);
      end
   endfunction

   function automatic void adv4(input bit r);
      exp_t e;
      e.onebit = 1'b0;
      if (!r) begin
         k4 = 0;
         v4 = 1'b1;
      end else if (v4) begin
         k4 = (k4 + 1) % 16;
         e.onebit = 1'b1;
      end
      if (v4) begin
         e.gray = tab[k4];
         q4.push_back(e);
      end
   endfunction

   // Falling rst between edges must not disturb the output before the next edge.
   task automatic hold_check(input bit h3, input bit h4);
      if (h3 || h4) begin
         #1;
         if (h3) check("hold3", 16'(g3), tab[k3]);
         if (h4) check("hold4", 16'(g4), tab[k4]);
      end
   endtask

   task automatic step(input bit r3, input bit r4);
      bit h3, h4;
      @(negedge clk);
      h3 = !r3 && (rst3 === 1'b1) && v3;
      h4 = !r4 && (rst4 === 1'b1) && v4;
      rst3 = r3;
      rst4 = r4;
      hold_check(h3, h4);
      adv3(r3);
      adv4(r4);
   endtask

   task automatic pulse();
      bit h3, h4;
      @(negedge clk);
      h3 = (rst3 === 1'b1) && v3;
      h4 = (rst4 === 1'b1) && v4;
      rst3 = 1'b0;
      rst4 = 1'b0;
      hold_check(h3, h4);
      #2;
      rst3 = 1'b1;
      rst4 = 1'b1;
      adv3(1'b1);
      adv4(1'b1);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [15:0] prev3 = '0;
      logic [15:0] prev4 = '0;
      forever begin
         @(posedge clk);
         #1;
         if (q3.size() > 0) begin
            e = q3.pop_front();
            check("gray3", 16'(g3), e.gray);
            if (e.onebit) check("step3", 16'($countones(g3 ^ prev3[2:0])), 16'd1);
            prev3 = e.gray;
         end
         if (q4.size() > 0) begin
            e = q4.pop_front();
            check("gray4", 16'(g4), e.gray);
            if (e.onebit) check("step4", 16'($countones(g4 ^ prev4[3:0])), 16'd1);
            prev4 = e.gray;
         end
      end
   end

   initial begin : stimulus
      tab[0] = 16'd0;
      tab[1] = 16'd1;
      for (int n = 1; n < 4; n++)
         for (int i = 0; i < (1 << n); i++)
            tab[(1 << n) + i] = 16'(1 << n) | tab[(1 << n) - 1 - i];

      // Reset for two edges, then a full WIDTH=3 period and a full WIDTH=4 period.
      repeat (2) step(1'b0, 1'b0);
      repeat (16) step(1'b1, 1'b1);

      repeat (500) step(1'b1, 1'b1);

      // Count to 110, hold reset for 50 edges, then release.
      step(1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b1);
      repeat (50) step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b1);

      // Short reset pulses entirely between edges.
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(1, 9)) step(1'b1, 1'b1);
         pulse();
      end

      // Random reset activity, independent per instance, with occasional pulses.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) pulse();
      end

      repeat (2) @(negedge clk);
      check("drain", 16'(q3.size() + q4.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be named clk and rst, with rst asserted when low and sampled only on the rising edge of clk.
REQ-002 Parameter WIDTH, default 3: counter width in bits; legal values are 2 to 16.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1 bit: synchronous active-low reset (0 = reset, 1 = count).
REQ-005 Port Gray_output, output, WIDTH bits: current count in reflected binary Gray code, driven directly from a register.
REQ-006 There SHALL be no other ports; the block counts on every clock while rst is high (no enable).

Function
REQ-007 The block SHALL hold an internal WIDTH-bit binary count register bin.
- Gray_output SHALL equal bin XOR (bin >> 1), registered, so Gray_output always matches bin.
REQ-008 On each rising clk edge with rst=1:
- bin SHALL become bin+1 modulo 2^WIDTH.
- Gray_output SHALL take the Gray code of the new bin in the same edge.
- Latency: exactly one Gray step per clock.
REQ-009 For WIDTH=3, the output sequence after reset SHALL be 000, 001, 011, 010, 110, 111, 101, 100, then wrap to 000 and repeat.
REQ-010 Consecutive Gray_output values, including the wrap from the last code back to 000, SHALL differ in exactly one bit.
REQ-011 Wrap-around: after the all-ones binary state (Gray 100 for WIDTH=3), the next edge SHALL produce bin=0 and Gray_output=0.
- No overflow flag and no saturation.
REQ-012 Gray_output SHALL change only at rising clk edges and SHALL be glitch-free between edges.
- It SHALL not be a combinational function of rst.
REQ-013 The count period SHALL be 2^WIDTH clock cycles (8 for WIDTH=3).

Reset
REQ-014 On a rising clk edge with rst=0, bin SHALL become 0 and Gray_output SHALL become 0, overriding counting.
REQ-015 While rst stays low, Gray_output SHALL remain 0 on every edge.
REQ-016 On the first rising edge with rst=1 after reset, Gray_output SHALL become 0...01 (001 for WIDTH=3).
REQ-017 Reset asserted mid-sequence SHALL take effect at the next rising edge regardless of the current count.
- Before that edge, Gray_output SHALL keep its current value.
REQ-018 A rst pulse low between clock edges that is deasserted before the next edge SHALL have no effect.
REQ-019 Register values before the first reset are undefined; the bench SHALL apply reset before checking.

Verification
REQ-020 Hold rst=0 for 2 edges -> Gray_output=000 after each edge; release rst=1 -> the next 8 edges give 001,011,010,110,111,101,100,000.
REQ-021 Run 500 consecutive edges with rst=1 -> every transition changes exactly one bit, and the pattern repeats with period 8.
REQ-022 Count to Gray 110 (4 edges after reset), drive rst=0 for 50 edges -> 000 at the first edge and held at 000; on release, the first edge gives 001.
REQ-023 Pulse rst low between two edges, restoring it high before the next edge -> no reset occurs and the count continues unchanged.
REQ-024 Instantiate with WIDTH=4, reset, then run 16 edges -> the sequence follows the standard 4-bit reflected Gray code, ends at 1000, and wraps to 0000.
REQ-025 At every edge, a reference model checks Gray_output against the Gray code of a cycle count held modulo 2^WIDTH since the last reset.
